// File: rtl/spike_ctrl_pkg.sv
// Shared definitions for the spike serialiser control path: FSM encoding and requester count.
package spike_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer of the last winner.
module rr_arbiter2
    import spike_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    // last = index of the most recent winner; reset to 1 so requester 0 wins the first tie
    logic last;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (gnt[0]) begin
            last <= 1'b0;
        end else if (gnt[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/spike_serial_arbiter.sv
// Arbitrates two word requesters onto an external shift register and streams each word LSB first.
module spike_serial_arbiter
    import spike_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   req_data0,
    input  logic [WIDTH-1:0]   req_data1,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               clear,
    output logic               sr_init,
    output logic               sr_load,
    output logic               sr_shift,
    output logic [WIDTH-1:0]   sr_data,
    input  logic               sr_bit,
    output logic               bit_out,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               arb_en;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               last_bit;

    // Outputs are gated by rst_n so nothing leaks out while reset is held
    assign arb_en   = rst_n && !clear && (state == ST_IDLE);
    assign last_bit = (count == CNT_W'(1));

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    always_comb begin
        gnt       = arb_gnt;
        sr_load   = |arb_gnt;
        sr_data   = '0;
        sr_init   = 1'b0;
        sr_shift  = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;
        busy      = rst_n && (state == ST_SHIFT);
        if (arb_gnt[1]) begin
            sr_data = req_data1;
        end else if (arb_gnt[0]) begin
            sr_data = req_data0;
        end
        if (rst_n) begin
            if (clear) begin
                sr_init = 1'b1;
            end else if (state == ST_SHIFT) begin
                bit_valid = 1'b1;
                bit_out   = sr_bit;
                sr_shift  = bit_ready;
                done      = bit_ready && last_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (clear) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        state <= ST_SHIFT;
                        count <= CNT_W'(WIDTH);
                    end
                end
                ST_SHIFT: begin
                    if (bit_ready) begin
                        count <= count - CNT_W'(1);
                        if (last_bit) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_serial_arbiter.sv
// Bench for spike_serial_arbiter: models the external shift register and checks against a word/bit queue model.
module tb_spike_serial_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] gnt;
    logic       clear;
    logic       sr_init;
    logic       sr_load;
    logic       sr_shift;
    logic [7:0] sr_data;
    logic       sr_bit;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic       done;

    spike_serial_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .gnt       (gnt),
        .clear     (clear),
        .sr_init   (sr_init),
        .sr_load   (sr_load),
        .sr_shift  (sr_shift),
        .sr_data   (sr_data),
        .sr_bit    (sr_bit),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift register driven by the DUT strobes
    logic [7:0] sr;
    initial sr = 8'h00;
    always @(posedge clk) begin
        if (sr_init)       sr <= 8'h00;
        else if (sr_load)  sr <= sr_data;
        else if (sr_shift) sr <= sr >> 1;
    end
    assign sr_bit = sr[0];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a word in flight is just a queue of bits still to be accepted
    bit       m_busy;
    bit       m_last;
    bit       m_bits[$];

    // Observed statistics per scenario
    int         n_busy, n_done, n_acc, n_init;
    logic [7:0] acc_word;
    logic [1:0] g_obs;
    logic [1:0] g_log[$];
    logic [1:0] exp_gnt_last;

    task automatic clr_stats();
        n_busy = 0; n_done = 0; n_acc = 0; n_init = 0;
        acc_word = 8'h00; g_obs = 2'b00;
        g_log.delete();
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 1'b1;
        m_bits.delete();
    endtask

    task automatic step(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                        input logic rdy, input logic clr);
        logic [1:0] e_gnt;
        logic [7:0] e_data;
        logic e_init, e_load, e_shift, e_valid, e_out, e_done;
        int pick;
        @(negedge clk);
        req = r; req_data0 = d0; req_data1 = d1; bit_ready = rdy; clear = clr;
        #1;
        e_gnt = 2'b00; e_data = 8'h00; e_init = 0; e_load = 0; e_shift = 0;
        e_valid = 0; e_out = 0; e_done = 0; pick = 0;
        if (clr) begin
            e_init = 1;
        end else if (!m_busy) begin
            if (r != 2'b00) begin
                if (r == 2'b11) pick = (m_last == 1'b0) ? 1 : 0;
                else            pick = r[0] ? 0 : 1;
                e_gnt  = 2'(1 << pick);
                e_load = 1;
                e_data = (pick == 1) ? d1 : d0;
            end
        end else begin
            e_valid = 1;
            e_out   = m_bits[0];
            e_shift = rdy;
            e_done  = rdy && (m_bits.size() == 1);
        end
        chk("gnt",       32'(gnt),       32'(e_gnt));
        chk("sr_init",   32'(sr_init),   32'(e_init));
        chk("sr_load",   32'(sr_load),   32'(e_load));
        chk("sr_shift",  32'(sr_shift),  32'(e_shift));
        chk("sr_data",   32'(sr_data),   32'(e_data));
        chk("bit_valid", 32'(bit_valid), 32'(e_valid));
        chk("bit_out",   32'(bit_out),   32'(e_out));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("done",      32'(done),      32'(e_done));
        if (busy) n_busy++;
        if (done) n_done++;
        if (sr_init) n_init++;
        if (bit_valid && bit_ready) begin
            n_acc++;
            acc_word = {bit_out, acc_word[7:1]};
        end
        g_obs = gnt;
        if (gnt != 2'b00) g_log.push_back(gnt);
        exp_gnt_last = e_gnt;
        if (clr) begin
            m_busy = 0;
            m_bits.delete();
        end else if (!m_busy && r != 2'b00) begin
            m_busy = 1;
            m_last = pick[0];
            m_bits.delete();
            for (int i = 0; i < 8; i++) m_bits.push_back(e_data[i]);
        end else if (m_busy && rdy) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_busy = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 2'b11; bit_ready = 1'b1; clear = 1'b0;
        req_data0 = 8'hFF; req_data1 = 8'hFF;
        #1;
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_strb",  32'({sr_init, sr_load, sr_shift}), 0);
        chk("rst_data",  32'(sr_data), 0);
        chk("rst_bit",   32'({bit_out, bit_valid}), 0);
        chk("rst_stat",  32'({busy, done}), 0);
        #2;
        req = 2'b00; bit_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] pend;
        logic [7:0] pdata0, pdata1;
        rst_n = 1'b0; req = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
        clear = 1'b0; bit_ready = 1'b0;
        model_reset();
        clr_stats();

        // Single requester, continuous ready
        do_reset();
        clr_stats();
        step(2'b01, 8'hA5, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("a5_word", 32'(acc_word), 32'h0A5);
        chk("a5_busy", n_busy, 8);
        chk("a5_done", n_done, 1);
        chk("a5_gnts", g_log.size(), 1);

        // Both requesters held: alternating grants
        do_reset();
        clr_stats();
        for (int i = 0; i < 30; i++) step(2'b11, 8'h0F, 8'hF0, 1'b1, 1'b0);
        chk("rr_cnt", 32'(g_log.size() >= 3), 1);
        if (g_log.size() >= 3) begin
            chk("rr_g0", 32'(g_log[0]), 1);
            chk("rr_g1", 32'(g_log[1]), 2);
            chk("rr_g2", 32'(g_log[2]), 1);
        end

        // Stall for three cycles after bit 2
        do_reset();
        clr_stats();
        step(2'b01, 8'h81, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("stall_busy", n_busy, 11);
        chk("stall_acc",  n_acc, 8);
        chk("stall_done", n_done, 1);
        chk("stall_word", 32'(acc_word), 32'h081);

        // Clear on bit 5 with requester 1 pending
        do_reset();
        clr_stats();
        step(2'b01, 8'h3C, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b10, 8'h00, 8'h99, 1'b1, 1'b0);
        step(2'b10, 8'h00, 8'h99, 1'b1, 1'b1);
        chk("clr_init", n_init, 1);
        chk("clr_done", n_done, 0);
        step(2'b10, 8'h00, 8'h99, 1'b1, 1'b0);
        chk("clr_regnt", 32'(g_obs), 2);

        // Reset during bit 3, then a tie must go to requester 0
        do_reset();
        clr_stats();
        step(2'b01, 8'h6D, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
        do_reset();
        step(2'b11, 8'h11, 8'h22, 1'b1, 1'b0);
        chk("rst_tie", 32'(g_obs), 1);

        // Randomised traffic with stalls and occasional clears
        do_reset();
        clr_stats();
        pend = 2'b00; pdata0 = 8'h00; pdata1 = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if (!pend[0] && ($urandom_range(3) == 0)) begin
                pend[0] = 1'b1; pdata0 = 8'($urandom);
            end
            if (!pend[1] && ($urandom_range(3) == 0)) begin
                pend[1] = 1'b1; pdata1 = 8'($urandom);
            end
            step(pend, pdata0, pdata1, ($urandom_range(3) != 0), ($urandom_range(49) == 0));
            pend = pend & ~exp_gnt_last;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_serial_arbiter.md
SPIKE_SERIAL_ARBITER -- requirements
Module: spike_serial_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the word width of the controlled shift register and the number of bits emitted per word.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), is the bit-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  2  per-requester word-valid; req[i] held until gnt[i].
REQ-006 req_data0, req_data1  input  WIDTH  parallel words from requester 0 and requester 1.
REQ-007 gnt  output  2  one-cycle accept pulse, onehot or zero.
REQ-008 clear  input  1  synchronous abort and register-init request.
REQ-009 sr_init, sr_load, sr_shift  output  1 each  control strobes to the external shift register, mutually exclusive.
REQ-010 sr_data  output  WIDTH  word presented with sr_load.
REQ-011 sr_bit  input  1  LSB of the external shift register.
REQ-012 bit_out  output  1  serial spike bit; equals sr_bit while bit_valid.
REQ-013 bit_valid  output  1  bit_out qualifier.
REQ-014 bit_ready  input  1  downstream accepts bit_out when bit_valid && bit_ready.
REQ-015 busy  output  1  high in SHIFT.
REQ-016 done  output  1  one-cycle pulse on acceptance of the last bit of a word.

Function
REQ-017 The FSM SHALL have the states IDLE and SHIFT.
REQ-018 IDLE, clear=0, any req: grant one requester by round-robin, pulse gnt[i] and sr_load, drive sr_data=req_data_i, load count=WIDTH, and go to SHIFT.
REQ-019 Round-robin: if both requests are high, grant the requester not granted last; a single request is granted regardless of pointer; the pointer updates only on a grant.
REQ-020 IDLE, no req: all strobes 0 and sr_data 0; stay in IDLE.
REQ-021 SHIFT: bit_valid=1, bit_out=sr_bit, busy=1; on bit_ready, pulse sr_shift and decrement count; without bit_ready, hold all state and bit_out (stall).
REQ-022 SHIFT with bit_ready and count==1: pulse done and sr_shift, go to IDLE; WIDTH accepted bits per word, LSB first.
REQ-023 Back-to-back words SHALL have exactly one IDLE cycle between the last accepted bit and the next bit_valid cycle.
REQ-024 clear in any state: pulse sr_init only, no gnt/done/bit_valid that cycle, count 0, and go to IDLE; clear wins over a simultaneous req or last-bit acceptance.
REQ-025 A requester dropping req mid-word SHALL NOT affect the word in flight.
REQ-026 Strobe outputs, gnt, bit_out and bit_valid SHALL be combinational from state/count/inputs; state, count and rr pointer are registered.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, count 0, and the rr pointer to favour requester 0 on the first tie.
REQ-028 During and after reset, all outputs SHALL be 0 until the first qualifying input.
REQ-029 Reset mid-word SHALL abandon the word with no done pulse.

Structure
REQ-030 The state encoding (IDLE, SHIFT) and the requester count (2) SHALL live in a shared package spike_ctrl_pkg.
REQ-031 One sub-module SHALL be used: rr_arbiter2 (2-way round-robin grant plus pointer); the FSM and counter SHALL remain in this module.

Verification (WIDTH=8, bench models the shift register)
REQ-032 req=01, data0=0xA5, bit_ready=1 -> gnt=01 one cycle, then bit_out 1,0,1,0,0,1,0,1 over 8 cycles, done on 8th, busy 8 cycles.
REQ-033 req=11 held, data0=0x0F, data1=0xF0 -> grants 01, then 10, then 01, with one IDLE cycle between words.
REQ-034 bit_ready low for 3 cycles after bit 2 of 0x81 -> bit_out held, no sr_shift; total 11 SHIFT cycles, 8 accepted bits, single done.
REQ-035 clear asserted on bit 5 -> sr_init pulse, no done, IDLE next cycle; a pending req is granted the following cycle.
REQ-036 rst_n low during bit 3 -> all outputs 0 immediately; after release with req=11 -> gnt=01.
